// File: rtl/fake_n64_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : fake_n64_pkg                                           |
// | Description : Shared state encoding, timing defaults and Joybus      |
// |               command codes for the fake N64 controller.             |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package fake_n64_pkg;

  // Receiver state encoding
  localparam int STATE_SIZE = 3;

  typedef enum logic [STATE_SIZE-1:0] {
    ST_IDLE    = 3'd0,
    ST_LOW     = 3'd1,
    ST_HIGH    = 3'd2,
    ST_HANDOFF = 3'd3,
    ST_ERROR   = 3'd4
  } rx_state_t;

  // Line timing defaults, shared with the transmitter
  localparam int LEVEL_WIDTH_DEFAULT = 2;
  localparam int BIT_WIDTH_DEFAULT   = 4 * LEVEL_WIDTH_DEFAULT;

  // Console command codes
  localparam logic [7:0] CMD_INFO   = 8'h00;
  localparam logic [7:0] CMD_STATUS = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_WRITE  = 8'h03;
  localparam logic [7:0] CMD_RESET  = 8'hff;

endpackage
`default_nettype wire

// File: rtl/n64_line_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : n64_line_sync                                          |
// | Description : Multi-flop synchroniser for the Joybus line. Resets to |
// |               1 so an idle (pulled-up) bus is seen during reset.     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module n64_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sample_clk,
  input  logic reset_n,
  input  logic data_rx,
  output logic s
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw line through the synchroniser chain
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_rx};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/fake_n64_controller_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fake_n64_controller_rx                                 |
// | Description : Joybus console-command receiver. Measures low pulses   |
// |               on the synchronised line, assembles the command byte,  |
// |               checks the stop bit and hands the bus to the           |
// |               transmitter on a clean frame.                          |
// |               Optional: FAKE_N64_RX_GLITCH_FILTER_EN drops low       |
// |               pulses shorter than one level as glitches.             |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module fake_n64_controller_rx
  import fake_n64_pkg::*;
#(
  parameter int LEVEL_WIDTH = LEVEL_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int CMD_BITS    = 8,
  parameter int IDLE_CYCLES = 16
) (
  input  logic       sample_clk,
  input  logic       reset_n,
  input  logic       data_rx,
  input  logic       rx_handoff,
  output logic [7:0] cmd,
  output logic       cmd_valid,
  output logic       cur_operation,
  output logic       frame_err
);

  localparam int BIT_WIDTH = 4 * LEVEL_WIDTH;
  localparam int CW        = $clog2(IDLE_CYCLES + 1);

  localparam logic [CW-1:0] C_ONE        = CW'(1);
  localparam logic [CW-1:0] C_LEVEL      = CW'(LEVEL_WIDTH);
  localparam logic [CW-1:0] C_HALF_BIT   = CW'(2 * LEVEL_WIDTH);
  localparam logic [CW-1:0] C_BIT_WIDTH  = CW'(BIT_WIDTH);
  localparam logic [CW-1:0] C_CMD_BITS   = CW'(CMD_BITS);
  localparam logic [CW-1:0] C_FRAME_BITS = CW'(CMD_BITS + 1);
  localparam logic [CW-1:0] C_BIT_SAT    = CW'(CMD_BITS + 2);
  localparam logic [CW:0]   C_IDLE       = (CW+1)'(IDLE_CYCLES);

  logic          s;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] low_q, low_d;
  logic [CW-1:0] high_q, high_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          last_q, last_d;
  logic [7:0]    cmd_d;
  logic          cmd_valid_d, cur_op_d, frame_err_d;
  logic          rx_bit;
  logic          glitch;
  logic [CW:0]   high_inc;

  n64_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .sample_clk (sample_clk),
    .reset_n    (reset_n),
    .data_rx    (data_rx),
    .s          (s)
  );

  // A short low is a '1', a long low is a '0'
  assign rx_bit   = (low_q < C_HALF_BIT);
  assign high_inc = {1'b0, high_q} + (CW+1)'(1);

`ifdef FAKE_N64_RX_GLITCH_FILTER_EN
  assign glitch = (low_q < C_LEVEL);
`else
  assign glitch = 1'b0;
`endif

  // State, counters and output registers
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      low_q         <= '0;
      high_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      last_q        <= 1'b0;
      cmd           <= '0;
      cmd_valid     <= 1'b0;
      cur_operation <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state_q       <= state_d;
      low_q         <= low_d;
      high_q        <= high_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      last_q        <= last_d;
      cmd           <= cmd_d;
      cmd_valid     <= cmd_valid_d;
      cur_operation <= cur_op_d;
      frame_err     <= frame_err_d;
    end
  end

  // Next-state, pulse decode and frame acceptance
  always_comb begin
    state_d     = state_q;
    low_d       = low_q;
    high_d      = high_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    last_d      = last_q;
    cmd_d       = cmd;
    cmd_valid_d = 1'b0;
    cur_op_d    = cur_operation;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!s) begin
          state_d = ST_LOW;
          low_d   = C_ONE;
          bit_d   = '0;
          shift_d = '0;
        end
      end

      ST_LOW: begin
        if (!s) begin
          if (low_q >= C_BIT_WIDTH) begin
            // Line stuck low: abandon the frame
            state_d     = ST_ERROR;
            frame_err_d = 1'b1;
            high_d      = '0;
          end else begin
            low_d = low_q + C_ONE;
          end
        end else if (glitch) begin
          // Too short to be a bit: resume the high phase as if it never dipped
          state_d = ST_HIGH;
          high_d  = high_q + low_q;
        end else begin
          if (bit_q < C_CMD_BITS) begin
            shift_d = {shift_q[6:0], rx_bit};
          end
          if (bit_q != C_BIT_SAT) begin
            bit_d = bit_q + C_ONE;
          end
          last_d  = rx_bit;
          state_d = ST_HIGH;
          high_d  = C_ONE;
        end
      end

      ST_HIGH: begin
        if (!s) begin
          state_d = ST_LOW;
          low_d   = C_ONE;
        end else if (high_inc >= C_IDLE) begin
          high_d = '0;
          if ((bit_q == C_FRAME_BITS) && last_q) begin
            cmd_d       = shift_q;
            cmd_valid_d = 1'b1;
            cur_op_d    = 1'b1;
            state_d     = ST_HANDOFF;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end else begin
          high_d = high_q + C_ONE;
        end
      end

      ST_HANDOFF: begin
        // Transmitter owns the line; only its completion matters
        if (rx_handoff) begin
          cur_op_d = 1'b0;
          state_d  = ST_ERROR;
          high_d   = '0;
        end
      end

      ST_ERROR: begin
        // Wait for a quiet bus before listening again
        if (!s) begin
          high_d = '0;
        end else if (high_inc >= C_IDLE) begin
          high_d  = '0;
          state_d = ST_IDLE;
        end else begin
          high_d = high_q + C_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fake_n64_controller_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fake_n64_controller_rx                              |
// | Description : Directed self-checking bench for the Joybus receiver   |
// |               (LEVEL_WIDTH = 2: '0' = 6 low/2 high, '1' = 2 low/6).  |
// |               Glitch expectations follow                             |
// |               FAKE_N64_RX_GLITCH_FILTER_EN.                          |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_fake_n64_controller_rx;

  logic       clk;
  logic       reset_n;
  logic       data_rx;
  logic       rx_handoff;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic       cur_operation;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int v0, f0;

  fake_n64_controller_rx #(
    .LEVEL_WIDTH (2),
    .SYNC_STAGES (2),
    .CMD_BITS    (8),
    .IDLE_CYCLES (16)
  ) dut (
    .sample_clk    (clk),
    .reset_n       (reset_n),
    .data_rx       (data_rx),
    .rx_handoff    (rx_handoff),
    .cmd           (cmd),
    .cmd_valid     (cmd_valid),
    .cur_operation (cur_operation),
    .frame_err     (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output pulses away from the active edge
  always @(negedge clk) begin
    if (cmd_valid) valid_cnt = valid_cnt + 1;
    if (frame_err) ferr_cnt = ferr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold the line at v for n cycles (called at a falling edge)
  task automatic drive(input logic v, input int n);
    repeat (n) begin
      data_rx = v;
      @(negedge clk);
    end
  endtask

  task automatic send_bit(input logic b);
    if (b) begin
      drive(1'b0, 2);
      drive(1'b1, 6);
    end else begin
      drive(1'b0, 6);
      drive(1'b1, 2);
    end
  endtask

  // Send the first nbits of b, MSB first, without the stop bit
  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(b[7-i]);
  endtask

  task automatic handoff();
    rx_handoff = 1'b1;
    @(negedge clk);
    rx_handoff = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    data_rx    = 1'b1;
    rx_handoff = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cmd", {24'd0, cmd}, 32'h00);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_cur_op", {31'd0, cur_operation}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset_n = 1'b1;
    drive(1'b1, 4);

    // 8'h01 + stop: cmd_valid exactly 18 cycles after the stop's rising edge
    send_bits(8'h01, 8);
    drive(1'b0, 2);
    data_rx = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 17) begin
        check("t1_valid_early", {31'd0, cmd_valid}, 32'd0);
        check("t1_curop_early", {31'd0, cur_operation}, 32'd0);
      end
      if (k == 18) begin
        check("t1_valid_pulse", {31'd0, cmd_valid}, 32'd1);
        check("t1_cmd", {24'd0, cmd}, 32'h01);
        check("t1_curop", {31'd0, cur_operation}, 32'd1);
      end
      if (k == 19) check("t1_valid_single", {31'd0, cmd_valid}, 32'd0);
    end
    drive(1'b1, 10);
    handoff();
    check("t1_handoff", {31'd0, cur_operation}, 32'd0);
    drive(1'b1, 20);

    // Only 7 bits + stop: rejected, cmd unchanged
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_bits(8'hA4, 7);
    send_bit(1'b1);
    drive(1'b1, 24);
    check("t3_ferr_cnt", ferr_cnt - f0, 32'd1);
    check("t3_no_valid", valid_cnt - v0, 32'd0);
    check("t3_cmd_kept", {24'd0, cmd}, 32'h01);

    // Reset mid-frame clears outputs at once; next frame decodes
    send_bits(8'hA0, 4);
    drive(1'b0, 3);
    reset_n = 1'b0;
    #1;
    check("t5_rst_cmd", {24'd0, cmd}, 32'h00);
    check("t5_rst_curop", {31'd0, cur_operation}, 32'd0);
    check("t5_rst_valid", {31'd0, cmd_valid}, 32'd0);
    @(negedge clk);
    data_rx = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 20);
    v0 = valid_cnt;
    send_bits(8'h01, 8);
    send_bit(1'b1);
    drive(1'b1, 24);
    check("t5_valid_cnt", valid_cnt - v0, 32'd1);
    check("t5_cmd", {24'd0, cmd}, 32'h01);
    handoff();
    drive(1'b1, 20);

    // 8'hff + stop, handoff 40 cycles later, then 8'h00
    v0 = valid_cnt;
    send_bits(8'hFF, 8);
    drive(1'b0, 2);
    drive(1'b1, 40);
    check("t2_valid_cnt", valid_cnt - v0, 32'd1);
    check("t2_cmd_ff", {24'd0, cmd}, 32'hFF);
    check("t2_curop_tx", {31'd0, cur_operation}, 32'd1);
    handoff();
    check("t2_curop_rx", {31'd0, cur_operation}, 32'd0);
    drive(1'b1, 20);
    v0 = valid_cnt;
    send_bits(8'h00, 8);
    send_bit(1'b1);
    drive(1'b1, 24);
    check("t2_valid_00", valid_cnt - v0, 32'd1);
    check("t2_cmd_00", {24'd0, cmd}, 32'h00);
    handoff();
    drive(1'b1, 20);

    // Line stuck low 12 cycles mid-frame: frame_err on low cycle 9 (+2 sync)
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_bits(8'h50, 4);
    data_rx = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 10) check("t4_ferr_early", {31'd0, frame_err}, 32'd0);
      if (k == 11) check("t4_ferr_pulse", {31'd0, frame_err}, 32'd1);
      if (k == 12) check("t4_ferr_single", {31'd0, frame_err}, 32'd0);
    end
    drive(1'b1, 10);
    // A frame arriving before 16 quiet cycles is ignored
    send_bits(8'h01, 8);
    send_bit(1'b1);
    drive(1'b1, 24);
    check("t4_no_valid", valid_cnt - v0, 32'd0);
    check("t4_ferr_once", ferr_cnt - f0, 32'd1);

    // 8'h00 with a 1-cycle low inside the high phase of bit 3
    v0 = valid_cnt;
    f0 = ferr_cnt;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        drive(1'b0, 6);
        drive(1'b1, 1);
        drive(1'b0, 1);
        drive(1'b1, 1);
      end else begin
        send_bit(1'b0);
      end
    end
    send_bit(1'b1);
    drive(1'b1, 24);
`ifdef FAKE_N64_RX_GLITCH_FILTER_EN
    check("t6_valid_cnt", valid_cnt - v0, 32'd1);
    check("t6_ferr_cnt", ferr_cnt - f0, 32'd0);
    check("t6_cmd", {24'd0, cmd}, 32'h00);
`else
    check("t6_valid_cnt", valid_cnt - v0, 32'd0);
    check("t6_ferr_cnt", ferr_cnt - f0, 32'd1);
    check("t6_curop", {31'd0, cur_operation}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
